pipelined_adder_nbit: RTL and testbench
=======================================

Name: pipelined_adder_nbit

Overview:
- Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake on both sides.
- Splits the operand into SEG-bit segments, one segment per pipeline stage, carry registered between stages; closes timing for wide datapaths where a flat ripple adder does not.
- Sits between an operand source (e.g. register file or stimulus FIFO) and a result consumer; supersedes the fixed 4-bit combinational adder for datapaths of 8 bits and up.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits added per pipeline stage; STAGES = WIDTH/SEG (latency in cycles).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A (unsigned / two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry-in, used only when sub=0
- sub  in  1  1: A - B, 0: A + B + cin
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub=1: 1 means no borrow, i.e. A >= B unsigned)
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync deassert external): all stage valid bits 0, all data/carry registers 0; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 one cycle after reset deasserts.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. The whole pipeline shifts on adv; it holds all registers when adv=0. No bubbles are collapsed; a bubble travels as valid=0.
- Input transfer: in_valid && in_ready. On transfer, stage 0 stores a, b_eff = sub ? ~b : b, c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds segment k of a and b_eff with the carry from stage k-1 (c0 for k=0), writes sum segment k and the new carry, and forwards the untouched upper segments of a and b_eff plus the already-computed lower sum segments.
- Stage STAGES-1 also records the carry into its MSB bit to compute ovf.
- Latency: the result appears at the output STAGES cycles after transfer when unstalled. Throughput is 1 beat/cycle. Results leave in input order.
- Output holds sum/cout/ovf stable while out_valid && !out_ready.
- Simultaneous in transfer and out transfer in one cycle is legal and required for full throughput.
- Wrap-around: sum is modulo 2^WIDTH; cout carries the lost bit.
- Reset mid-operation: all in-flight beats are discarded and no out_valid is asserted until new beats traverse the pipeline.
- STAGES=1 (SEG=WIDTH) is legal: a single registered adder with latency 1.

Decomposition:
- No shared package needed; STAGES is a localparam.
- Sub-module adder_seg: combinational SEG-bit ripple adder (a, b, ci -> s, co, c_msb_in), instantiated once per stage via generate.

Test Plan (WIDTH=16, SEG=4, out_ready=1 unless stated):
- a=0x0005, b=0x0003, cin=0, sub=0 -> sum=0x0008, cout=0, ovf=0, out_valid exactly 4 cycles after transfer.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Exercises the full carry chain across all stages.
- sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1. Check cin is ignored when sub=1.
- 8 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low in exactly those cycles, sum held stable, all 8 results in order with none lost or duplicated.
- Random in_valid/out_ready, 1000 beats, sub/cin random -> every result matches a reference model and ordering is preserved.
- rst_n pulsed low with 3 beats in flight -> outputs zero immediately, no stale out_valid afterwards; a fresh beat 0x1234+0x0001 -> 0x1235 with latency 4.

Source files
------------

// File: rtl/adder_seg.sv
// One SEG-bit slice of the pipelined adder: plain combinational ripple-carry.
// Exposes the carry into its top bit so the last slice can flag signed overflow.
module adder_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           ci_i,
  output logic [SEG-1:0] s_o,
  output logic           co_o,
  output logic           cm_o
);

  logic [SEG:0] c;

  always_comb begin
    c      = '0;
    s_o    = '0;
    c[0]   = ci_i;
    for (int i = 0; i < SEG; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o = c[SEG];
  assign cm_o = c[SEG-1];

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit add/subtract, one SEG-bit slice per stage, with a single
// global advance shared by every stage (no bubble collapsing).
module pipelined_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  logic              adv;
  logic              fire;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [STAGES-1:0] vld_pipe_q;
  logic              ovf_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign fire     = in_valid && adv;
  // Subtraction is A + ~B + 1; cin is ignored in that mode.
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe_q <= '0;
    else if (adv) vld_pipe_q <= (vld_pipe_q << 1) | STAGES'(fire);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int HI = WIDTH - (k + 1) * SEG;  // operand bits not yet added
    localparam int LO = (k + 1) * SEG;          // sum bits done after this stage

    logic [HI+SEG-1:0] a_src, b_src;
    logic              c_src, co, cm;
    logic [SEG-1:0]    s_seg;
    logic [LO-1:0]     s_d, s_q;
    logic              c_q;

    if (k == 0) begin : g_in
      assign a_src = a;
      assign b_src = b_eff;
      assign c_src = c0;
      assign s_d   = s_seg;
    end else begin : g_mid
      assign a_src = g_stg[k-1].g_fwd.a_q;
      assign b_src = g_stg[k-1].g_fwd.b_q;
      assign c_src = g_stg[k-1].c_q;
      assign s_d   = {s_seg, g_stg[k-1].s_q};
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a_i  (a_src[SEG-1:0]),
      .b_i  (b_src[SEG-1:0]),
      .ci_i (c_src),
      .s_o  (s_seg),
      .co_o (co),
      .cm_o (cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_d;
        c_q <= co;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [HI-1:0] a_q, b_q;
      logic          unused_cm;
      assign unused_cm = cm;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[HI+SEG-1:SEG];
          b_q <= b_src[HI+SEG-1:SEG];
        end
      end
    end else begin : g_out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= cm ^ co;
      end
    end
  end

  assign out_valid = vld_pipe_q[STAGES-1];
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench for pipelined_adder_nbit (WIDTH=16, SEG=4): expected
// {ovf,cout,sum} queued on input transfer, popped on output transfer.
module tb_pipelined_adder_nbit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  pipelined_adder_nbit #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [17:0] res;
    int          cyc;
    bit          lat_en;
  } sb_t;

  sb_t         sb[$];
  sb_t         e_in, e_out;
  int          n_chk = 0, n_fail = 0, cyc = 0, n_in = 0, n_out = 0;
  logic [17:0] cur_exp = '0;
  bit          cur_lat = 1'b0;
  bit          hold_pend = 1'b0;
  logic [17:0] hold_val = '0;
  bit          drv_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: {ovf, cout, sum}; overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] ma, mb, input logic mc, ms);
    logic [15:0] bb;
    logic [16:0] t;
    logic        v;
    bb = ms ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, bb} + {16'b0, (ms ? 1'b1 : mc)};
    v  = (ma[15] == bb[15]) && (t[15] != ma[15]);
    return {v, t[16], t[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {ovf, cout, sum}, hold_val);
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {ovf, cout, sum};
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e_out = sb.pop_front();
          chk("result", {ovf, cout, sum}, e_out.res);
          if (e_out.lat_en) chk("latency", cyc - e_out.cyc, 4);
        end
      end
      if (in_valid && in_ready) begin
        n_in++;
        e_in.res    = cur_exp;
        e_in.cyc    = cyc;
        e_in.lat_en = cur_lat;
        sb.push_back(e_in);
      end
    end
  end

  task automatic send(input logic [15:0] ta, tb_, input logic tc, ts, input logic [17:0] ex);
    bit ok;
    a = ta; b = tb_; cin = tc; sub = ts; cur_exp = ex; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, o0, stale;
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {ovf, cout, sum}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed corner cases, back to back, latency checked
    cur_lat = 1'b1;
    send(16'h0005, 16'h0003, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0008});
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b0, 1'b1, 16'hFFFF});
    drain();
    cur_lat = 1'b0;

    // 8 beats with a 3-cycle consumer stall mid-stream
    i0 = n_in; o0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = 16'(i * 16'h1357 + 16'h0101);
          rb = 16'(i * 16'h0F0F);
          send(ra, rb, i[0], i[1], model(ra, rb, i[0], i[1]));
        end
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) chk("stall_wait_timeout", 0, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_in_ready", in_ready, 1);
      end
    join
    drain();
    chk("stall_in_count", n_in - i0, 8);
    chk("stall_out_count", n_out - o0, 8);

    // Random traffic with random backpressure
    i0 = n_in; o0 = n_out;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic rc, rs;
          idle($urandom_range(0, 2));
          ra = 16'($urandom); rb = 16'($urandom);
          rc = 1'($urandom); rs = 1'($urandom);
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_in_count", n_in - i0, 1000);
    chk("rand_out_count", n_out - o0, 1000);

    // Reset with 3 beats in flight
    send(16'h1111, 16'h0001, 1'b0, 1'b0, model(16'h1111, 16'h0001, 1'b0, 1'b0));
    send(16'h2222, 16'h0002, 1'b0, 1'b0, model(16'h2222, 16'h0002, 1'b0, 1'b0));
    send(16'h3333, 16'h0003, 1'b0, 1'b0, model(16'h3333, 16'h0003, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs", {ovf, cout, sum}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    @(posedge clk); #1;
    chk("no_stale_valid", stale, 0);
    cur_lat = 1'b1;
    send(16'h1234, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1235});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
